lap_record_reader: RTL and testbench
====================================

LAP_RECORD_READER -- requirements
Module: lap_record_reader

Interface
REQ-001 SHALL have parameter SCAN_TICKS, default 2, meaning the number of tick_1hz pulses per auto-scan step (legal range 1..15).
REQ-002 SHALL have parameter BLANK_VALUE, default 24'h000000, meaning the disp_data value when no record is shown.
REQ-003 SHALL have port clk_50Mhz, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rec_count, input, 5 bits: number of valid lap records held in RAM (0..16); values above 16 are treated as 16.
REQ-006 SHALL have port key_next, input, 1 bit: one-cycle debounced pulse that steps to the next record.
REQ-007 SHALL have port key_prev, input, 1 bit: one-cycle debounced pulse that steps to the previous record.
REQ-008 SHALL have port key_scan, input, 1 bit: one-cycle pulse that toggles auto-scan mode.
REQ-009 SHALL have port tick_1hz, input, 1 bit: one-cycle pulse at 1 Hz.
REQ-010 SHALL have port ram_q, input, 24 bits: RAM read data, valid on the edge after the edge at which ram_addr was sampled.
REQ-011 SHALL have port ram_addr, output, 4 bits: RAM read address.
REQ-012 SHALL have port rd_active, output, 1 bit: high while the reader owns the RAM address port; the writer must not write while it is high.
REQ-013 SHALL have port disp_data, output, 24 bits: the displayed BCD lap record.
REQ-014 SHALL have port disp_index, output, 5 bits: 1-based index of the shown record, or 0 when no record is shown.
REQ-015 SHALL have port disp_valid, output, 1 bit: high when disp_data holds a fetched record.
REQ-016 SHALL have port empty, output, 1 bit: high when rec_count==0.
REQ-017 SHALL have port scan_on, output, 1 bit: auto-scan mode active.

Function
REQ-018 SHALL implement states IDLE, FETCH, WAIT and SHOW.
REQ-019 SHALL, on a step event sampled at edge E in IDLE or SHOW, load cur_idx and ram_addr with the new index and enter FETCH at E.
REQ-020 SHALL go from FETCH to WAIT at E+1, and from WAIT to SHOW at E+2 while latching disp_data<=ram_q, disp_index<=cur_idx+1 and disp_valid<=1.
REQ-021 SHALL drive rd_active high exactly in FETCH and WAIT.
REQ-022 SHALL drop key_next, key_prev and auto-scan steps that occur in FETCH or WAIT; key_scan toggles are still honoured in those states.
REQ-023 SHALL step to cur_idx+1 on next, wrapping from rec_count-1 to 0.
REQ-024 SHALL step to cur_idx-1 on prev, wrapping from 0 to rec_count-1.
REQ-025 SHALL treat key_next and key_prev asserted in the same cycle as no step.
REQ-026 SHALL apply a key_scan toggle in the same cycle as a coincident step.
REQ-027 SHALL, in auto-scan mode, count tick_1hz pulses with a 4-bit counter and generate a next step when the count reaches SCAN_TICKS, then clear the counter.
REQ-028 SHALL clear the tick counter on any manual step and on entry to auto-scan.
REQ-029 SHALL, when rec_count==0, force state to IDLE, scan_on=0, disp_valid=0, disp_index=0 and disp_data=BLANK_VALUE, and ignore all keys.
REQ-030 SHALL, when rec_count goes from 0 to nonzero while in IDLE, automatically fetch index 0 with the same timing as a step event.
REQ-031 SHALL, when in SHOW with cur_idx>=rec_count (rec_count shrank), automatically fetch index rec_count-1.
REQ-032 SHALL, when rec_count drops to 0 in FETCH or WAIT, abort the fetch and apply REQ-029 on the next edge.

Reset
REQ-033 SHALL, on rst=1 at an edge (including mid-fetch), set state=IDLE, cur_idx=0, ram_addr=0, tick counter=0, rd_active=0, disp_data=BLANK_VALUE, disp_index=0, disp_valid=0 and scan_on=0; empty reflects rec_count combinationally.
REQ-034 SHALL, on the first edge after rst deasserts with rec_count nonzero, perform the REQ-030 auto-fetch.

Verification
REQ-035 SHALL be covered by: rec_count 0->3 with RAM[0]=24'h012345 -> rd_active high for 2 cycles, then disp_data=24'h012345, disp_index=1, disp_valid=1.
REQ-036 SHALL be covered by: rec_count=3, showing index 3, key_next -> ram_addr=0, disp_index=1; then key_prev -> ram_addr=2, disp_index=3.
REQ-037 SHALL be covered by: key_next during WAIT, and key_next with key_prev in the same cycle -> no index change in either case.
REQ-038 SHALL be covered by: key_scan with SCAN_TICKS=2 and rec_count=2 -> disp_index advances once every 2 ticks, 1->2->1; key_scan again -> scan_on=0 and index frozen.
REQ-039 SHALL be covered by: showing index 5, rec_count 8->4 -> auto-fetch with ram_addr=3 and disp_index=4; then rec_count->0 -> disp_data=BLANK_VALUE and empty=1.
REQ-040 SHALL be covered by: rst asserted in FETCH -> outputs match REQ-033 values on the next edge; RAM contents unaffected.

Source files
------------

// File: rtl/lap_record_reader.sv
// rtl/lap_record_reader.sv - browses stored lap records from RAM and presents one on the display
//
// Purpose: steps through up to 16 lap records held in a synchronous-read RAM,
// either manually (next/prev keys) or automatically (auto-scan on 1 Hz ticks).
// Each step issues a two-cycle fetch and then latches the record for display.
//
// Ports:
//   clk_50Mhz  in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   rec_count  in   number of valid records (values above 16 read as 16)
//   key_next   in   one-cycle pulse: step forward
//   key_prev   in   one-cycle pulse: step backward
//   key_scan   in   one-cycle pulse: toggle auto-scan
//   tick_1hz   in   one-cycle pulse at 1 Hz
//   ram_q      in   RAM read data, one edge after the address is sampled
//   ram_addr   out  RAM read address
//   rd_active  out  reader owns the RAM port (writer must hold off)
//   disp_data  out  displayed BCD record
//   disp_index out  1-based index of the shown record, 0 when none
//   disp_valid out  disp_data holds a fetched record
//   empty      out  no records stored
//   scan_on    out  auto-scan mode active
module lap_record_reader #(
  parameter int unsigned SCAN_TICKS  = 2,
  parameter logic [23:0] BLANK_VALUE = 24'h000000
) (
  input  logic        clk_50Mhz,
  input  logic        rst,
  input  logic [4:0]  rec_count,
  input  logic        key_next,
  input  logic        key_prev,
  input  logic        key_scan,
  input  logic        tick_1hz,
  input  logic [23:0] ram_q,
  output logic [3:0]  ram_addr,
  output logic        rd_active,
  output logic [23:0] disp_data,
  output logic [4:0]  disp_index,
  output logic        disp_valid,
  output logic        empty,
  output logic        scan_on
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_SHOW} state_t;

  localparam logic [4:0] LP_TICKS = 5'(SCAN_TICKS);

  state_t      r_state;
  logic [3:0]  r_cur_idx;
  logic [3:0]  r_ram_addr;
  logic [3:0]  r_tick_cnt;
  logic        r_rd_active;
  logic [23:0] r_disp_data;
  logic [4:0]  r_disp_index;
  logic        r_disp_valid;
  logic        r_scan_on;

  logic [4:0]  w_count;
  logic        w_empty;
  logic [3:0]  w_last_idx;
  logic        w_key_next;
  logic        w_key_prev;
  logic        w_tick_hit;
  logic        w_shrunk;
  logic [3:0]  w_next_idx;
  logic [3:0]  w_prev_idx;
  logic        w_do_fetch;
  logic        w_manual_step;
  logic [3:0]  w_fetch_idx;

  assign w_count    = (rec_count > 5'd16) ? 5'd16 : rec_count;
  assign w_empty    = (w_count == 5'd0);
  assign w_last_idx = 4'(w_count - 5'd1);

  // Both keys in the same cycle cancel out.
  assign w_key_next = key_next & ~key_prev;
  assign w_key_prev = key_prev & ~key_next;

  assign w_tick_hit = r_scan_on & tick_1hz & (({1'b0, r_tick_cnt} + 5'd1) == LP_TICKS);

  // The record list shrank underneath the shown record.
  assign w_shrunk   = ({1'b0, r_cur_idx} >= w_count);

  assign w_next_idx = (r_cur_idx == w_last_idx) ? 4'd0 : r_cur_idx + 4'd1;
  assign w_prev_idx = (r_cur_idx == 4'd0) ? w_last_idx : r_cur_idx - 4'd1;

  // Fetch decision; only IDLE and SHOW accept new work, so steps that
  // arrive mid-fetch are dropped here.
  always_comb begin
    w_do_fetch    = 1'b0;
    w_manual_step = 1'b0;
    w_fetch_idx   = r_cur_idx;
    if (r_state == S_IDLE) begin
      w_do_fetch  = 1'b1;
      w_fetch_idx = 4'd0;
    end else if (r_state == S_SHOW) begin
      if (w_shrunk) begin
        w_do_fetch  = 1'b1;
        w_fetch_idx = w_last_idx;
      end else if (w_key_next) begin
        w_do_fetch    = 1'b1;
        w_manual_step = 1'b1;
        w_fetch_idx   = w_next_idx;
      end else if (w_key_prev) begin
        w_do_fetch    = 1'b1;
        w_manual_step = 1'b1;
        w_fetch_idx   = w_prev_idx;
      end else if (w_tick_hit) begin
        w_do_fetch  = 1'b1;
        w_fetch_idx = w_next_idx;
      end
    end
  end

  always_ff @(posedge clk_50Mhz) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cur_idx    <= 4'd0;
      r_ram_addr   <= 4'd0;
      r_tick_cnt   <= 4'd0;
      r_rd_active  <= 1'b0;
      r_disp_data  <= BLANK_VALUE;
      r_disp_index <= 5'd0;
      r_disp_valid <= 1'b0;
      r_scan_on    <= 1'b0;
    end else if (w_empty) begin
      // Nothing to show: park, blank the display, ignore all keys.
      r_state      <= S_IDLE;
      r_tick_cnt   <= 4'd0;
      r_rd_active  <= 1'b0;
      r_disp_data  <= BLANK_VALUE;
      r_disp_index <= 5'd0;
      r_disp_valid <= 1'b0;
      r_scan_on    <= 1'b0;
    end else begin
      // Scan toggle is honoured in every state; the counter restarts on
      // any toggle and on every applied manual step.
      if (key_scan) begin
        r_scan_on  <= ~r_scan_on;
        r_tick_cnt <= 4'd0;
      end else if (w_manual_step) begin
        r_tick_cnt <= 4'd0;
      end else if (r_scan_on && tick_1hz) begin
        r_tick_cnt <= w_tick_hit ? 4'd0 : r_tick_cnt + 4'd1;
      end

      case (r_state)
        S_IDLE, S_SHOW: begin
          if (w_do_fetch) begin
            r_cur_idx   <= w_fetch_idx;
            r_ram_addr  <= w_fetch_idx;
            r_rd_active <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_disp_data  <= ram_q;
          r_disp_index <= {1'b0, r_cur_idx} + 5'd1;
          r_disp_valid <= 1'b1;
          r_rd_active  <= 1'b0;
          r_state      <= S_SHOW;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ram_addr   = r_ram_addr;
  assign rd_active  = r_rd_active;
  assign disp_data  = r_disp_data;
  assign disp_index = r_disp_index;
  assign disp_valid = r_disp_valid;
  assign empty      = w_empty;
  assign scan_on    = r_scan_on;

endmodule

// File: tb/tb_lap_record_reader.sv
// tb/tb_lap_record_reader.sv - self-checking bench for lap_record_reader
`timescale 1ns/1ps
module tb_lap_record_reader;

  localparam logic [23:0] BLANK = 24'h000000;

  logic        clk_50Mhz = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rec_count = 5'd0;
  logic        key_next = 1'b0;
  logic        key_prev = 1'b0;
  logic        key_scan = 1'b0;
  logic        tick_1hz = 1'b0;
  logic [23:0] ram_q;
  logic [3:0]  ram_addr;
  logic        rd_active;
  logic [23:0] disp_data;
  logic [4:0]  disp_index;
  logic        disp_valid;
  logic        empty;
  logic        scan_on;

  logic [23:0] mem [16];

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk_50Mhz = ~clk_50Mhz;

  // Synchronous-read RAM: data appears one edge after the address is sampled.
  always @(posedge clk_50Mhz) ram_q <= mem[ram_addr];

  lap_record_reader #(.SCAN_TICKS(2), .BLANK_VALUE(BLANK)) dut (
    .clk_50Mhz (clk_50Mhz),
    .rst       (rst),
    .rec_count (rec_count),
    .key_next  (key_next),
    .key_prev  (key_prev),
    .key_scan  (key_scan),
    .tick_1hz  (tick_1hz),
    .ram_q     (ram_q),
    .ram_addr  (ram_addr),
    .rd_active (rd_active),
    .disp_data (disp_data),
    .disp_index(disp_index),
    .disp_valid(disp_valid),
    .empty     (empty),
    .scan_on   (scan_on)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50Mhz);
      #1;
    end
  endtask

  task automatic pulse(input logic n, input logic p, input logic s, input logic t);
    key_next = n; key_prev = p; key_scan = s; tick_1hz = t;
    cyc();
    key_next = 1'b0; key_prev = 1'b0; key_scan = 1'b0; tick_1hz = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int n;
    int op;
    int v;

    for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
    mem[0] = 24'h012345;

    // Reset with no records.
    cyc(2);
    rst = 1'b0;
    cyc();
    check("rst_data",  disp_data,  BLANK);
    check("rst_index", disp_index, 0);
    check("rst_valid", disp_valid, 0);
    check("rst_empty", empty,      1);
    check("rst_scan",  scan_on,    0);
    check("rst_rdact", rd_active,  0);
    check("rst_addr",  ram_addr,   0);

    // 0 -> 3 records: auto-fetch of record 0 with a two-cycle read window.
    rec_count = 5'd3;
    cyc();
    check("first_rdact0", rd_active, 1);
    check("first_addr",   ram_addr,  0);
    cyc();
    check("first_rdact1", rd_active, 1);
    cyc();
    check("first_rdact2", rd_active,  0);
    check("first_data",   disp_data,  24'h012345);
    check("first_index",  disp_index, 1);
    check("first_valid",  disp_valid, 1);

    // Wrap backward to index 3, forward to 1, backward to 3.
    pulse(0, 1, 0, 0);
    check("prev_wrap_addr", ram_addr, 2);
    cyc(2);
    check("prev_wrap_index", disp_index, 3);
    check("prev_wrap_data",  disp_data,  mem[2]);
    pulse(1, 0, 0, 0);
    check("next_wrap_addr", ram_addr, 0);
    cyc(2);
    check("next_wrap_index", disp_index, 1);
    pulse(0, 1, 0, 0);
    check("prev_again_addr", ram_addr, 2);
    cyc(2);
    check("prev_again_index", disp_index, 3);

    // Key during WAIT is dropped; both keys at once is no step.
    pulse(1, 0, 0, 0);
    cyc();
    pulse(1, 0, 0, 0);
    cyc(3);
    check("drop_wait_index", disp_index, 1);
    pulse(1, 1, 0, 0);
    check("both_keys_rdact", rd_active, 0);
    cyc(3);
    check("both_keys_index", disp_index, 1);

    // Auto-scan over 2 records, step every 2 ticks.
    rec_count = 5'd2;
    cyc(2);
    pulse(0, 0, 1, 0);
    check("scan_on", scan_on, 1);
    pulse(0, 0, 0, 1); cyc(3);
    check("scan_tick1", disp_index, 1);
    pulse(0, 0, 0, 1); cyc(3);
    check("scan_tick2", disp_index, 2);
    pulse(0, 0, 0, 1); cyc(3);
    check("scan_tick3", disp_index, 2);
    pulse(0, 0, 0, 1); cyc(3);
    check("scan_tick4", disp_index, 1);
    pulse(0, 0, 1, 0);
    check("scan_off", scan_on, 0);
    for (int i = 0; i < 4; i++) begin
      pulse(0, 0, 0, 1); cyc(3);
    end
    check("scan_frozen", disp_index, 1);

    // Shrink from 8 to 4 records while showing index 5.
    rec_count = 5'd8;
    cyc(2);
    for (int i = 0; i < 4; i++) begin
      pulse(1, 0, 0, 0); cyc(2);
    end
    check("show5_index", disp_index, 5);
    rec_count = 5'd4;
    cyc();
    check("shrink_addr",  ram_addr,  3);
    check("shrink_rdact", rd_active, 1);
    cyc(2);
    check("shrink_index", disp_index, 4);
    check("shrink_data",  disp_data,  mem[3]);
    rec_count = 5'd0;
    #1;
    check("zero_empty", empty, 1);
    cyc();
    check("zero_data",  disp_data,  BLANK);
    check("zero_index", disp_index, 0);
    check("zero_valid", disp_valid, 0);
    pulse(1, 0, 1, 0);
    check("zero_keys_rdact", rd_active, 0);
    check("zero_keys_scan",  scan_on,   0);

    // Count above 16 is treated as 16.
    rec_count = 5'd20;
    cyc(3);
    check("clamp_first", disp_index, 1);
    pulse(0, 1, 0, 0); cyc(2);
    check("clamp_index", disp_index, 16);
    check("clamp_data",  disp_data,  mem[15]);

    // Reset during FETCH.
    pulse(1, 0, 0, 0);
    check("pre_rst_rdact", rd_active, 1);
    rst = 1'b1;
    cyc();
    check("midrst_addr",  ram_addr,   0);
    check("midrst_rdact", rd_active,  0);
    check("midrst_data",  disp_data,  BLANK);
    check("midrst_index", disp_index, 0);
    check("midrst_valid", disp_valid, 0);
    check("midrst_scan",  scan_on,    0);
    rst = 1'b0;
    cyc(3);
    check("postrst_index", disp_index, 1);
    check("postrst_data",  disp_data,  24'h012345);

    // Randomized browsing against a wrap-around index model.
    idx = 0;
    for (int k = 0; k < 40; k++) begin
      v = $urandom_range(1, 31);
      n = (v > 16) ? 16 : v;
      rec_count = 5'(v);
      if (idx >= n) idx = n - 1;
      cyc(4);
      check("rnd_count_index", disp_index, idx + 1);
      op = $urandom_range(0, 2);
      case (op)
        0: begin pulse(1, 0, 0, 0); idx = (idx + 1) % n; end
        1: begin pulse(0, 1, 0, 0); idx = (idx + n - 1) % n; end
        default: pulse(1, 1, 0, 0);
      endcase
      cyc(2);
      check("rnd_key_index", disp_index, idx + 1);
      check("rnd_key_data",  disp_data,  mem[idx]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
